// File: rtl/uart_ctrl_arb.sv
// uart_ctrl_arb: round-robin arbiter feeding one UART transmitter, plus a
// single-entry capture buffer with overrun detection on the UART receive side.
module uart_ctrl_arb #(
    parameter int NUM_REQ      = 4,
    parameter int DW           = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         tx_data,
    output logic                  tx_send,
    input  logic                  tx_busy,
    output logic                  tx_err,
    input  logic                  rx_flag,
    input  logic [DW-1:0]         rx_data,
    input  logic                  parity_error,
    output logic                  rx_flag_clr,
    output logic [DW-1:0]         rx_out_data,
    output logic                  rx_out_perr,
    output logic                  rx_out_valid,
    input  logic                  rx_out_ready,
    output logic                  rx_overrun,
    input  logic                  err_clr
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state;
    logic [GW-1:0] grant, last_grant, pick, j;
    logic [CW-1:0] cnt;
    logic [NUM_REQ-1:0] avail;
    logic tx_err_set, rx_take, rx_accept, rx_ign;
    // a requester whose ack is on the bus this cycle has not had a chance to drop req yet
    assign avail      = req & ~ack;
    assign tx_err_set = (state == WAIT_BUSY) && !tx_busy && (cnt == CW'(BUSY_TIMEOUT - 1));
    assign rx_take    = rx_flag && !rx_flag_clr && !rx_ign;
    assign rx_accept  = !rx_out_valid || rx_out_ready;
    // walk downward so the nearest set bit after last_grant is the one left in pick
    always_comb begin
        pick = last_grant;
        j    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = GW'((int'(last_grant) + k) % NUM_REQ);
            if (avail[j]) pick = j;
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            cnt        <= '0;
            ack        <= '0;
            tx_send    <= 1'b0;
            tx_data    <= '0;
            tx_err     <= 1'b0;
        end else begin
            ack     <= '0;
            tx_send <= 1'b0;
            tx_err  <= tx_err_set || (tx_err && !err_clr);
            case (state)
                IDLE: if (|avail) begin
                    grant   <= pick;
                    tx_data <= req_data[int'(pick)*DW +: DW];
                    tx_send <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) begin
                    state <= WAIT_DONE;
                end else if (tx_err_set) begin
                    ack        <= NUM_REQ'(1) << grant;
                    last_grant <= grant;
                    state      <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WAIT_DONE: if (!tx_busy) begin
                    ack        <= NUM_REQ'(1) << grant;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // the UART flag is still high during the clear pulse and the cycle after it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_flag_clr  <= 1'b0;
            rx_ign       <= 1'b0;
            rx_out_data  <= '0;
            rx_out_perr  <= 1'b0;
            rx_out_valid <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_flag_clr <= rx_take;
            rx_ign      <= rx_flag_clr;
            rx_overrun  <= (rx_take && !rx_accept) || (rx_overrun && !err_clr);
            if (rx_take && rx_accept) begin
                rx_out_data  <= rx_data;
                rx_out_perr  <= parity_error;
                rx_out_valid <= 1'b1;
            end else if (rx_out_valid && rx_out_ready) begin
                rx_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_ctrl_arb.sv
// tb_uart_ctrl_arb: directed scenarios plus randomized request batches, with a
// cycle-level UART stand-in and a round-robin order model.
module tb_uart_ctrl_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    logic clk = 1'b0, n_rst = 1'b1;
    logic [N-1:0] req = '0, ack, ack_val = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [DW-1:0] tx_data, rx_data = '0, rx_out_data, send_data = '0, ack_data = '0;
    logic tx_send, tx_busy = 1'b0, tx_err, rx_flag = 1'b0, parity_error = 1'b0, rx_flag_clr;
    logic rx_out_perr, rx_out_valid, rx_out_ready = 1'b0, rx_overrun, err_clr = 1'b0;
    int n_cmp = 0, n_err = 0, cyc = 0, n_send = 0, n_ack = 0, n_clr = 0;
    int send_cyc = 0, ack_cyc = 0, busy_left = 0, frame_len = 10, cur_len = 10;
    bit uart_en = 1, rand_len = 0, auto_drop = 1, prev_send = 0, prev_clr = 0;

    uart_ctrl_arb #(.NUM_REQ(N), .DW(DW), .BUSY_TIMEOUT(15)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .tx_err(tx_err),
        .rx_flag(rx_flag), .rx_data(rx_data), .parity_error(parity_error),
        .rx_flag_clr(rx_flag_clr), .rx_out_data(rx_out_data), .rx_out_perr(rx_out_perr),
        .rx_out_valid(rx_out_valid), .rx_out_ready(rx_out_ready), .rx_overrun(rx_overrun),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // one clock: UART reacts to what it saw last cycle, then events of the new cycle are logged
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (busy_left > 0) begin
            busy_left--;
            tx_busy = (busy_left > 0);
        end else if (uart_en && prev_send) begin
            cur_len   = rand_len ? int'($urandom_range(1, 6)) : frame_len;
            busy_left = cur_len;
            tx_busy   = 1'b1;
        end
        prev_send = tx_send;
        if (tx_send) begin n_send++; send_cyc = cyc; send_data = tx_data; end
        if (prev_clr) rx_flag = 1'b0;
        prev_clr = rx_flag_clr;
        if (rx_flag_clr) n_clr++;
        if (ack != '0) begin
            n_ack++; ack_cyc = cyc; ack_val = ack; ack_data = tx_data;
            if (auto_drop) req = req & ~ack;
        end
    endtask

    task automatic wait_send(input int budget, output bit ok);
        int n0;
        n0 = n_send;
        for (int i = 0; i < budget && n_send == n0; i++) step();
        ok = (n_send != n0);
    endtask

    task automatic wait_ack(input int budget, output bit ok);
        int n0;
        n0 = n_ack;
        for (int i = 0; i < budget && n_ack == n0; i++) step();
        ok = (n_ack != n0);
    endtask

    task automatic do_reset();
        req = '0; rx_flag = 0; rx_out_ready = 0; err_clr = 0; tx_busy = 0;
        busy_left = 0; prev_send = 0; prev_clr = 0;
        n_rst = 1'b1; #2; n_rst = 1'b0;
        step(); step();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        req = '0; rx_flag = 0; tx_busy = 0;
        n_rst = 1'b1; #2; n_rst = 1'b0; #1;
        n_cmp++; if ({ack, tx_send, tx_data, tx_err, rx_flag_clr} !== '0) begin n_err++; $display("FAIL reset_tx got=%h exp=0", {ack, tx_send, tx_data, tx_err, rx_flag_clr}); end
        n_cmp++; if ({rx_out_data, rx_out_perr, rx_out_valid, rx_overrun} !== '0) begin n_err++; $display("FAIL reset_rx got=%h exp=0", {rx_out_data, rx_out_perr, rx_out_valid, rx_overrun}); end
        step(); step();
        n_rst = 1'b1;
        repeat (4) step();
        n_cmp++; if (n_send !== 0) begin n_err++; $display("FAIL idle_no_send got=%0d exp=0", n_send); end
    endtask

    task automatic test_single_tx();
        bit ok;
        do_reset();
        uart_en = 1; rand_len = 0; frame_len = 10; auto_drop = 1;
        req_data = {8'hC1, 8'hB2, 8'hA3, 8'h55};
        req = 4'b0001;
        wait_send(5, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_send got=none exp=pulse"); end
        n_cmp++; if (send_data !== 8'h55) begin n_err++; $display("FAIL single_data got=%h exp=55", send_data); end
        wait_ack(40, ok);
        n_cmp++; if (!ok || ack_val !== 4'b0001) begin n_err++; $display("FAIL single_ack got=%b exp=0001", ack_val); end
        n_cmp++; if (ack_cyc !== send_cyc + 12) begin n_err++; $display("FAIL single_latency got=%0d exp=%0d", ack_cyc - send_cyc, 12); end
        n_cmp++; if (ack_data !== 8'h55) begin n_err++; $display("FAIL single_hold got=%h exp=55", ack_data); end
        step();
        n_cmp++; if (ack !== '0) begin n_err++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
        repeat (3) step();
        n_cmp++; if (n_send !== 1) begin n_err++; $display("FAIL single_send_count got=%0d exp=1", n_send); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int idx, s0;
        logic [DW-1:0] b [N];
        do_reset();
        auto_drop = 0; frame_len = 3;
        for (int i = 0; i < N; i++) begin b[i] = 8'($urandom); req_data[i*DW +: DW] = b[i]; end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            idx = k % N;
            wait_ack(40, ok);
            if (k == 4) req = '0;
            n_cmp++; if (!ok || ack_val !== N'(1) << idx) begin n_err++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, ack_val, N'(1) << idx); end
            n_cmp++; if (send_data !== b[idx]) begin n_err++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, send_data, b[idx]); end
        end
        s0 = n_send;
        repeat (4) step();
        n_cmp++; if (n_send !== s0) begin n_err++; $display("FAIL rr_stop got=%0d exp=%0d", n_send, s0); end
        auto_drop = 1;
    endtask

    task automatic test_drop_early();
        bit ok;
        frame_len = 5;
        req_data[2*DW +: DW] = 8'h3C;
        req = 4'b0100;
        wait_send(8, ok);
        req = 4'b0000;
        req_data[2*DW +: DW] = 8'hEE;
        wait_ack(40, ok);
        n_cmp++; if (!ok || ack_val !== 4'b0100) begin n_err++; $display("FAIL drop_ack got=%b exp=0100", ack_val); end
        n_cmp++; if (send_data !== 8'h3C || ack_data !== 8'h3C) begin n_err++; $display("FAIL drop_data got=%h/%h exp=3c", send_data, ack_data); end
    endtask

    task automatic test_timeout();
        bit ok;
        uart_en = 0;
        req = 4'b0001;
        wait_send(8, ok);
        n_cmp++; if (tx_err !== 1'b0) begin n_err++; $display("FAIL to_err_early got=%b exp=0", tx_err); end
        wait_ack(40, ok);
        n_cmp++; if (!ok || ack_val !== 4'b0001) begin n_err++; $display("FAIL to_ack got=%b exp=0001", ack_val); end
        n_cmp++; if (ack_cyc !== send_cyc + 16) begin n_err++; $display("FAIL to_latency got=%0d exp=16", ack_cyc - send_cyc); end
        n_cmp++; if (tx_err !== 1'b1) begin n_err++; $display("FAIL to_err got=%b exp=1", tx_err); end
        step();
        n_cmp++; if (tx_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b exp=1", tx_err); end
        err_clr = 1; step(); err_clr = 0;
        n_cmp++; if (tx_err !== 1'b0) begin n_err++; $display("FAIL to_clear got=%b exp=0", tx_err); end
        err_clr = 1;
        req = 4'b0010;
        wait_ack(40, ok);
        n_cmp++; if (tx_err !== 1'b1) begin n_err++; $display("FAIL to_set_wins got=%b exp=1", tx_err); end
        step();
        err_clr = 0;
        n_cmp++; if (tx_err !== 1'b0) begin n_err++; $display("FAIL to_clear2 got=%b exp=0", tx_err); end
        uart_en = 1;
    endtask

    task automatic test_rx_capture();
        int c0;
        rx_out_ready = 0;
        c0 = n_clr;
        rx_data = 8'hA3; parity_error = 1; rx_flag = 1;
        step();
        n_cmp++; if ({rx_out_data, rx_out_perr, rx_out_valid} !== {8'hA3, 2'b11}) begin n_err++; $display("FAIL rx_capture got=%h/%b/%b exp=a3/1/1", rx_out_data, rx_out_perr, rx_out_valid); end
        n_cmp++; if (rx_flag_clr !== 1'b1) begin n_err++; $display("FAIL rx_clr got=%b exp=1", rx_flag_clr); end
        repeat (4) step();
        n_cmp++; if (n_clr !== c0 + 1) begin n_err++; $display("FAIL rx_clr_count got=%0d exp=%0d", n_clr - c0, 1); end
        n_cmp++; if (rx_overrun !== 1'b0 || rx_out_valid !== 1'b1) begin n_err++; $display("FAIL rx_hold got=%b/%b exp=0/1", rx_overrun, rx_out_valid); end
        rx_out_ready = 1; step(); rx_out_ready = 0;
        n_cmp++; if (rx_out_valid !== 1'b0) begin n_err++; $display("FAIL rx_consume got=%b exp=0", rx_out_valid); end
    endtask

    task automatic test_rx_overrun();
        int c0;
        c0 = n_clr;
        rx_data = 8'h11; parity_error = 0; rx_flag = 1;
        repeat (4) step();
        rx_data = 8'h22; parity_error = 1; rx_flag = 1;
        repeat (4) step();
        n_cmp++; if ({rx_out_data, rx_out_perr} !== {8'h11, 1'b0}) begin n_err++; $display("FAIL ovr_hold got=%h/%b exp=11/0", rx_out_data, rx_out_perr); end
        n_cmp++; if (rx_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got=%b exp=1", rx_overrun); end
        n_cmp++; if (n_clr !== c0 + 2) begin n_err++; $display("FAIL ovr_clr_count got=%0d exp=2", n_clr - c0); end
        err_clr = 1; step(); err_clr = 0;
        n_cmp++; if (rx_overrun !== 1'b0 || rx_out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_clear got=%b/%b exp=0/1", rx_overrun, rx_out_valid); end
    endtask

    task automatic test_rx_same_cycle();
        rx_data = 8'h77; parity_error = 0; rx_flag = 1; rx_out_ready = 1;
        step();
        rx_out_ready = 0;
        n_cmp++; if ({rx_out_data, rx_out_valid, rx_overrun} !== {8'h77, 2'b10}) begin n_err++; $display("FAIL same_cycle got=%h/%b/%b exp=77/1/0", rx_out_data, rx_out_valid, rx_overrun); end
        repeat (3) step();
        rx_out_ready = 1; step(); rx_out_ready = 0;
        n_cmp++; if (rx_out_valid !== 1'b0) begin n_err++; $display("FAIL same_drain got=%b exp=0", rx_out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int a0;
        do_reset();
        uart_en = 1; rand_len = 0; frame_len = 10; auto_drop = 1;
        req_data[0 +: DW] = 8'h9A;
        req = 4'b0001;
        wait_send(5, ok);
        repeat (4) step();
        a0 = n_ack;
        #2; n_rst = 1'b0; busy_left = 0; tx_busy = 0; prev_send = 0; #1;
        n_cmp++; if ({ack, tx_send, tx_data, tx_err, rx_flag_clr, rx_out_data, rx_out_perr, rx_out_valid, rx_overrun} !== '0) begin n_err++; $display("FAIL midrst_outputs got=nonzero exp=0"); end
        step(); step();
        n_rst = 1'b1;
        n_cmp++; if (n_ack !== a0) begin n_err++; $display("FAIL midrst_no_ack got=%0d exp=%0d", n_ack, a0); end
        wait_send(5, ok);
        n_cmp++; if (!ok || send_data !== 8'h9A) begin n_err++; $display("FAIL midrst_send got=%h exp=9a", send_data); end
        wait_ack(40, ok);
        n_cmp++; if (!ok || ack_val !== 4'b0001 || ack_cyc !== send_cyc + 12) begin n_err++; $display("FAIL midrst_ack got=%b@%0d exp=0001@12", ack_val, ack_cyc - send_cyc); end
    endtask

    task automatic test_random();
        bit ok;
        int last, q[$], idx;
        logic [N-1:0] mask;
        logic [DW-1:0] b [N];
        do_reset();
        uart_en = 1; rand_len = 1; auto_drop = 1;
        last = N - 1;
        for (int t = 0; t < 20; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin b[i] = 8'($urandom); req_data[i*DW +: DW] = b[i]; end
            q.delete();
            for (int k = 1; k <= N; k++) if (mask[(last + k) % N]) q.push_back((last + k) % N);
            req = mask;
            while (q.size() > 0) begin
                idx = q.pop_front();
                wait_ack(40, ok);
                n_cmp++; if (!ok || ack_val !== N'(1) << idx) begin n_err++; $display("FAIL rand_order t=%0d got=%b exp=%b", t, ack_val, N'(1) << idx); end
                n_cmp++; if (send_data !== b[idx]) begin n_err++; $display("FAIL rand_data t=%0d got=%h exp=%h", t, send_data, b[idx]); end
                n_cmp++; if (ack_cyc !== send_cyc + cur_len + 2) begin n_err++; $display("FAIL rand_latency t=%0d got=%0d exp=%0d", t, ack_cyc - send_cyc, cur_len + 2); end
                last = idx;
            end
            step();
        end
        rand_len = 0;
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_round_robin();
        test_drop_early();
        test_timeout();
        test_rx_capture();
        test_rx_overrun();
        test_rx_same_cycle();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
